// File: rtl/keccak_theta_dgen_if.sv
// Lane stream in / theta D stream out for keccak_theta_dgen.
// master drives lanes and consumes D; slave is the generator itself.
interface keccak_theta_dgen_if #(
   parameter int unsigned LANE_W = 64
);
   logic              clear;
   logic              in_valid;
   logic              in_ready;
   logic [LANE_W-1:0] in_lane;
   logic              out_valid;
   logic              out_ready;
   logic [LANE_W-1:0] out_d;
   logic [2:0]        out_x;
   logic              out_last;

   modport master (
      output clear, in_valid, in_lane, out_ready,
      input  in_ready, out_valid, out_d, out_x, out_last
   );

   modport slave (
      input  clear, in_valid, in_lane, out_ready,
      output in_ready, out_valid, out_d, out_x, out_last
   );
endinterface

// File: rtl/keccak_theta_dgen.sv
// Streaming Keccak theta D-lane generator.
// Accumulates column parities C[x] from 25 lanes (x fastest), then emits
// D[x] = C[x-1] ^ rotl1(C[x+1]) for x = 0..4. A second parity bank holds
// the emitted state so the next state can accumulate during the burst.
module keccak_theta_dgen #(
   parameter int unsigned LANE_W = 64
) (
   input logic              clk,
   input logic              rst_n,
   keccak_theta_dgen_if.slave bus
);

   typedef enum logic {
      IDLE,
      EMIT
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [2:0]        x_cnt;
   logic [2:0]        y_cnt;
   logic [2:0]        e_cnt;
   logic [LANE_W-1:0] acc [5];
   logic [LANE_W-1:0] emb [5];
   logic              busy;
   logic              accept;
   logic              last_lane;
   logic              fire;
   logic [2:0]        lo_idx;
   logic [2:0]        hi_idx;
   logic [LANE_W-1:0] c_lo;
   logic [LANE_W-1:0] c_hi;

   assign busy      = (state == EMIT);
   // Only the 25th lane can stall, and only while the emit bank is still draining.
   assign bus.in_ready = !((x_cnt == 3'd4) && (y_cnt == 3'd4) && busy);
   assign accept    = bus.in_valid && bus.in_ready;
   assign last_lane = accept && (x_cnt == 3'd4) && (y_cnt == 3'd4);
   assign fire      = busy && bus.out_ready;

   // Emission state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next emission state: clear aborts, 25th lane starts a burst, x=4 beat ends it
   always_comb begin
      state_nxt = state;
      if (bus.clear) begin
         state_nxt = IDLE;
      end else if (last_lane) begin
         state_nxt = EMIT;
      end else if (fire && (e_cnt == 3'd4)) begin
         state_nxt = IDLE;
      end
   end

   // Lane position counters (x fastest, then y)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (bus.clear) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (accept) begin
         if (x_cnt == 3'd4) begin
            x_cnt <= '0;
            y_cnt <= (y_cnt == 3'd4) ? 3'd0 : y_cnt + 3'd1;
         end else begin
            x_cnt <= x_cnt + 3'd1;
         end
      end
   end

   // Emission beat counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_cnt <= '0;
      end else if (bus.clear || last_lane) begin
         e_cnt <= '0;
      end else if (fire) begin
         e_cnt <= (e_cnt == 3'd4) ? 3'd0 : e_cnt + 3'd1;
      end
   end

   // Parity banks: y==0 overwrites so stale data after clear is harmless;
   // the 25th lane is folded straight into the emit bank on its accept edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 5; i++) begin
            acc[i] <= '0;
            emb[i] <= '0;
         end
      end else if (!bus.clear) begin
         if (accept) begin
            for (int unsigned i = 0; i < 5; i++) begin
               if (x_cnt == 3'(i)) begin
                  acc[i] <= (y_cnt == 3'd0) ? bus.in_lane : (acc[i] ^ bus.in_lane);
               end
            end
         end
         if (last_lane) begin
            for (int unsigned i = 0; i < 5; i++) begin
               emb[i] <= (i == 4) ? (acc[i] ^ bus.in_lane) : acc[i];
            end
         end
      end
   end

   // D lane for the current beat, from neighbours x-1 and x+1 (mod 5)
   always_comb begin
      lo_idx = (e_cnt == 3'd0) ? 3'd4 : e_cnt - 3'd1;
      hi_idx = (e_cnt == 3'd4) ? 3'd0 : e_cnt + 3'd1;
      c_lo   = '0;
      c_hi   = '0;
      for (int unsigned i = 0; i < 5; i++) begin
         if (lo_idx == 3'(i)) c_lo = emb[i];
         if (hi_idx == 3'(i)) c_hi = emb[i];
      end
      bus.out_d = busy ? (c_lo ^ {c_hi[LANE_W-2:0], c_hi[LANE_W-1]}) : '0;
   end

   assign bus.out_valid = busy;
   assign bus.out_x     = e_cnt;
   assign bus.out_last  = (e_cnt == 3'd4);

endmodule

// File: tb/tb_keccak_theta_dgen.sv
// Scoreboard bench for keccak_theta_dgen: expected D beats are queued when
// the 25th lane is accepted and popped as the DUT hands each beat over.
module tb_keccak_theta_dgen;

   typedef logic [63:0] lane_t;
   typedef struct packed {
      lane_t      d;
      logic [2:0] x;
      logic       last;
   } exp_t;

   logic  clk = 1'b0;
   logic  rst_n = 1'b0;
   int    vectors = 0;
   int    miscompares = 0;
   exp_t  sb[$];

   keccak_theta_dgen_if #(.LANE_W(64)) bus ();

   keccak_theta_dgen #(.LANE_W(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic lane_t model_d(input lane_t s[25], input int x);
      lane_t c[5];
      lane_t r;
      for (int k = 0; k < 5; k++) c[k] = '0;
      for (int i = 0; i < 25; i++) c[i % 5] ^= s[i];
      r = c[(x + 1) % 5];
      return c[(x + 4) % 5] ^ {r[62:0], r[63]};
   endfunction

   // Beat monitor: sample away from the rising edge; a beat is taken at the next posedge
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            check("spurious_beat", bus.out_valid, 1'b0);
         end else begin
            e = sb.pop_front();
            check("out_d", bus.out_d, e.d);
            check("out_x", {61'b0, bus.out_x}, {61'b0, e.x});
            check("out_last", {63'b0, bus.out_last}, {63'b0, e.last});
         end
      end
   end

   // Present n lanes; on the 25th accept, queue the five expected beats.
   task automatic send_lanes(input lane_t s[25], input int n, input lane_t ed[5],
                             input bit chk_lat, input bit chk_rdy);
      int  waited;
      bit  ok;
      exp_t e;
      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b1;
         bus.in_lane  = s[i];
         waited = 0;
         ok = 0;
         while (!ok) begin
            @(negedge clk);
            if (chk_rdy && i < 24 && waited == 0) check("in_ready_early", {63'b0, bus.in_ready}, 64'd1);
            if (bus.in_ready) begin
               ok = 1;
            end else begin
               waited++;
               if (waited > 300) begin
                  check("in_ready_timeout", {63'b0, bus.in_ready}, 64'd1);
                  bus.in_valid = 1'b0;
                  return;
               end
            end
         end
         if (chk_lat && i == 24) check("pre_lat_valid", {63'b0, bus.out_valid}, 64'd0);
         @(posedge clk);
         #1;
         if (i == 24) begin
            for (int x = 0; x < 5; x++) begin
               e.d = ed[x];
               e.x = 3'(x);
               e.last = (x == 4);
               sb.push_back(e);
            end
         end
      end
      bus.in_valid = 1'b0;
      if (chk_lat && n == 25) begin
         @(negedge clk);
         check("lat_valid", {63'b0, bus.out_valid}, 64'd1);
      end
   endtask

   task automatic model_exp(input lane_t s[25], output lane_t ed[5]);
      for (int x = 0; x < 5; x++) ed[x] = model_d(s, x);
   endtask

   task automatic rand_state(output lane_t s[25]);
      for (int i = 0; i < 25; i++) s[i] = {$urandom, $urandom};
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain", 64'(sb.size()), 64'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      lane_t s[25];
      lane_t s2[25];
      lane_t ed[5];
      lane_t ed2[5];
      int    n;

      bus.clear = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_lane = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
      check("rst_in_ready", {63'b0, bus.in_ready}, 64'd1);
      check("rst_out_d", bus.out_d, 64'd0);
      check("rst_out_x", {61'b0, bus.out_x}, 64'd0);
      check("rst_out_last", {63'b0, bus.out_last}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // All-zero state, latency check
      for (int i = 0; i < 25; i++) s[i] = '0;
      for (int x = 0; x < 5; x++) ed[x] = '0;
      send_lanes(s, 25, ed, 1'b1, 1'b0);
      drain();

      // Lane 0 = 1
      s[0] = 64'h1;
      ed[0] = '0; ed[1] = 64'h1; ed[2] = '0; ed[3] = '0; ed[4] = 64'h2;
      send_lanes(s, 25, ed, 1'b0, 1'b0);
      drain();

      // Lane 1 = MSB: rotation wraps into D[0]
      s[0] = '0;
      s[1] = 64'h8000_0000_0000_0000;
      ed[0] = 64'h1; ed[1] = '0; ed[2] = 64'h8000_0000_0000_0000; ed[3] = '0; ed[4] = '0;
      send_lanes(s, 25, ed, 1'b0, 1'b0);
      drain();

      // Back-to-back states with downstream stalled
      rand_state(s);
      rand_state(s2);
      model_exp(s, ed);
      model_exp(s2, ed2);
      bus.out_ready = 1'b0;
      fork
         begin
            send_lanes(s, 25, ed, 1'b0, 1'b0);
            send_lanes(s2, 25, ed2, 1'b0, 1'b1);
         end
         begin
            n = 0;
            while (!bus.out_valid && n < 200) begin
               @(negedge clk);
               n++;
            end
            repeat (40) begin
               @(negedge clk);
               check("hold_d", bus.out_d, ed[0]);
               check("hold_x", {61'b0, bus.out_x}, 64'd0);
               check("hold_valid", {63'b0, bus.out_valid}, 64'd1);
            end
            check("stall_in_ready", {63'b0, bus.in_ready}, 64'd0);
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      drain();

      // Abort after 13 lanes, then a fresh state
      rand_state(s);
      send_lanes(s, 13, ed, 1'b0, 1'b0);
      bus.clear = 1'b1;
      @(negedge clk);
      check("clear_valid", {63'b0, bus.out_valid}, 64'd0);
      @(posedge clk);
      #1;
      bus.clear = 1'b0;
      for (int i = 0; i < 25; i++) s[i] = '0;
      s[7] = '1;
      ed[0] = '0; ed[1] = '1; ed[2] = '0; ed[3] = '1; ed[4] = '0;
      send_lanes(s, 25, ed, 1'b0, 1'b0);
      drain();

      // Reset mid-burst after the x=1 beat
      rand_state(s);
      model_exp(s, ed);
      send_lanes(s, 25, ed, 1'b0, 1'b0);
      n = 0;
      while (!(bus.out_valid && bus.out_x == 3'd2) && n < 200) begin
         @(negedge clk);
         n++;
      end
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", {63'b0, bus.out_valid}, 64'd0);
      check("arst_in_ready", {63'b0, bus.in_ready}, 64'd1);
      check("arst_out_x", {61'b0, bus.out_x}, 64'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_valid", {63'b0, bus.out_valid}, 64'd0);
      @(posedge clk);
      #1;
      rand_state(s);
      model_exp(s, ed);
      send_lanes(s, 25, ed, 1'b1, 1'b0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/keccak_theta_dgen.md
Name: keccak_theta_dgen

Overview:
Streaming generator of the Keccak theta column-mix lanes D[x]. It consumes one state lane per cycle, XOR-accumulates the five column parities C[x], then emits D[x] = C[x-1] ^ rotl1(C[x+1]). It sits directly upstream of the DSP-inferred XOR slices. Each D[x] is the "two" operand XORed into every lane of column x. Parity storage is double-buffered, so the next state accumulates while the previous D burst drains.

Parameters:
LANE_W, 64, lane width in bits; rotl1 rotates by 1 modulo LANE_W.

Ports:
clk  in  1  single clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous abort; drops partial accumulation and any pending burst
in_valid  in  1  input lane valid
in_ready  out  1  input lane accepted when in_valid & in_ready
in_lane  in  LANE_W  state lane A[x][y]; lanes arrive in order i = x + 5*y, i = 0..24
out_valid  out  1  D lane valid
out_ready  in  1  downstream accepts when out_valid & out_ready
out_d  out  LANE_W  D[out_x]
out_x  out  3  column index 0..4
out_last  out  1  high on the x=4 beat

Behaviour:
- Reset (rst_n low, async):
  - x_cnt, y_cnt, e_cnt = 0.
  - Both parity banks = 0.
  - e_busy = 0, out_valid = 0, in_ready = 1.
  - out_d, out_x = 0; out_last = 0.
- Accumulate bank (acc), indexed by x_cnt:
  - On accept with y_cnt == 0: acc[x_cnt] <= in_lane (overwrite, no XOR with stale data).
  - On accept with y_cnt != 0: acc[x_cnt] <= acc[x_cnt] ^ in_lane.
  - x_cnt increments 0..4 and wraps. y_cnt increments when x_cnt wraps, 0..4, then wraps.
- Completion: the lane accepted with x_cnt = 4, y_cnt = 4 is the 25th lane.
  - On the following edge, the emit bank (emb) <= acc with the 25th lane folded in.
  - Same edge: e_busy <= 1, e_cnt <= 0, and both counters wrap to 0.
- in_ready = !(x_cnt == 4 && y_cnt == 4 && e_busy).
  - Only the 25th lane stalls, and only while the previous burst is still draining.
  - No combinational path from out_ready to in_ready.
- Emission:
  - out_valid = e_busy; out_x = e_cnt; out_last = (e_cnt == 4).
  - out_d = emb[(e_cnt+4)%5] ^ rotl1(emb[(e_cnt+1)%5]); all indices are mod 5.
  - rotl1(v) = {v[LANE_W-2:0], v[LANE_W-1]}.
  - On handshake, e_cnt increments. On the handshake with e_cnt == 4: e_busy <= 0 and e_cnt <= 0.
  - While out_valid & !out_ready, out_d, out_x and out_last hold stable.
- Latency: out_valid rises exactly 1 cycle after the 25th lane is accepted, when the bank is free.
- Simultaneous events:
  - Final emission beat and 25th lane accepted on the same edge is impossible, because in_ready is low then.
  - The 25th lane can be accepted on the cycle after the last beat; burst-to-burst gap minimum 1 idle cycle on out_valid.
  - Accept of non-final lanes during emission is fully concurrent.
- Clear takes priority over every other update on the same edge:
  - x_cnt, y_cnt, e_cnt = 0; e_busy = 0.
  - The in-flight lane and any undrained burst are discarded.
  - Bank contents need not be cleared, because the y==0 overwrite rule applies.
- Reset mid-operation returns to reset state immediately; no partial burst emitted after release.
- Throughput: steady state is 25 lanes in / 5 D out per 25 cycles with no input stall while out_ready stays high.

Test Plan:
- All 25 lanes = 0, out_ready = 1 -> 5 beats, out_d = 0 for x = 0..4, out_last only on x = 4, out_valid 1 cycle after the 25th accept.
- Lane 0 = 0x1, rest 0 -> D[1] = 0x1, D[4] = 0x2, D[0] = D[2] = D[3] = 0.
- Lane 1 (x=1) = 0x8000_0000_0000_0000, rest 0 -> D[0] = 0x1 (rotation wrap), D[2] = 0x8000_0000_0000_0000, others 0.
- Two back-to-back states, out_ready = 0 for 40 cycles:
  - first state's x = 0 beat is held stable;
  - in_ready drops only at the second state's 25th lane;
  - after out_ready rises, both bursts are correct in order.
- clear asserted after 13 lanes, then a fresh 25-lane state with lane 7 (x=2) = 0xFFFF_FFFF_FFFF_FFFF -> no output before the fresh state completes, then D[1] = D[3] = all-ones, D[0] = D[2] = D[4] = 0.
- rst_n pulsed low mid-burst (after the x = 1 beat) -> out_valid = 0 asynchronously, in_ready = 1; next full state produces correct D.
